// File: rtl/colon_display.sv
// Colon glyph renderer: flags raster pixels inside the two square dots of a
// fixed glyph box, with an optional frame-based blink. Output is registered.
module colon_display #(
  parameter logic [10:0] X_BOX        = 11'd700,
  parameter logic [9:0]  Y_BOX        = 10'd72,
  parameter int          BOX_W        = 20,
  parameter int          BOX_H        = 40,
  parameter int          DOT_X0       = 6,
  parameter int          DOT_X1       = 13,
  parameter int          TOP_Y0       = 8,
  parameter int          TOP_Y1       = 15,
  parameter int          BOT_Y0       = 24,
  parameter int          BOT_Y1       = 31,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_valid,
  input  logic        frame_tick,
  input  logic        blink_en,
  output logic        pixel_on
);

  localparam int            CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  // One extra bit on the box end bounds so X_BOX+BOX_W cannot overflow.
  localparam logic [11:0]   X_END    = {1'b0, X_BOX} + 12'(BOX_W);
  localparam logic [10:0]   Y_END    = {1'b0, Y_BOX} + 11'(BOX_H);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          visible_q, visible_d;
  logic          pixel_on_q, pixel_on_d;

  logic [10:0] rx;
  logic [9:0]  ry;
  logic        in_box;
  logic        dot_hit;
  logic        vis_eff;

  // Relative offsets are only formed once the low bounds are known to hold,
  // so an out-of-box coordinate can never wrap into the dot ranges.
  always_comb begin
    rx      = '0;
    ry      = '0;
    in_box  = (pixel_x >= X_BOX) && ({1'b0, pixel_x} < X_END) &&
              (pixel_y >= Y_BOX) && ({1'b0, pixel_y} < Y_END);
    if (in_box) begin
      rx = pixel_x - X_BOX;
      ry = pixel_y - Y_BOX;
    end
    dot_hit = in_box &&
              (rx >= 11'(DOT_X0)) && (rx <= 11'(DOT_X1)) &&
              (((ry >= 10'(TOP_Y0)) && (ry <= 10'(TOP_Y1))) ||
               ((ry >= 10'(BOT_Y0)) && (ry <= 10'(BOT_Y1))));
  end

  // Blink disabled overrides visibility immediately, so the colon reappears
  // on the very next pixel rather than waiting for the flag to reload.
  always_comb begin
    cnt_d     = cnt_q;
    visible_d = visible_q;
    if (!blink_en) begin
      cnt_d     = '0;
      visible_d = 1'b1;
    end else if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        visible_d = ~visible_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    vis_eff    = visible_q | ~blink_en;
    pixel_on_d = dot_hit & pixel_valid & vis_eff;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      visible_q  <= 1'b1;
      pixel_on_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      visible_q  <= visible_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  assign pixel_on = pixel_on_q;

endmodule

// File: tb/tb_colon_display.sv
// Self-checking bench for colon_display: directed points, gating, reset,
// blink sequencing, a window sweep and randomized traffic against a model.
module tb_colon_display;

  localparam int BF     = 2;
  localparam int X_BOX  = 700;
  localparam int Y_BOX  = 72;

  logic        clk;
  logic        rst_n;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        frame_tick;
  logic        blink_en;
  logic        pixel_on;

  int total;
  int bad;
  int tickCount;
  bit expOn;

  colon_display #(.BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .frame_tick  (frame_tick),
    .blink_en    (blink_en),
    .pixel_on    (pixel_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit pixels: dot columns 6..13 of the box, rows 8..15 or 24..31.
  function automatic bit dotModel(input int x, input int y);
    int rx;
    int ry;
    rx = x - X_BOX;
    ry = y - Y_BOX;
    return (rx >= 6) && (rx <= 13) &&
           (((ry >= 8) && (ry <= 15)) || ((ry >= 24) && (ry <= 31)));
  endfunction

  // Drives one pixel, predicts the flag for the following edge, then returns
  // 1 time unit after that edge so the caller can compare.
  task automatic driveCycle(input int x, input int y, input bit valid,
                            input bit tick, input bit ben, input bit rstN);
    bit visBefore;
    @(negedge clk);
    pixel_x     = 11'(x);
    pixel_y     = 10'(y);
    pixel_valid = valid;
    frame_tick  = tick;
    blink_en    = ben;
    rst_n       = rstN;
    visBefore   = ((tickCount / BF) % 2) == 0;
    if (!rstN) expOn = 1'b0;
    else       expOn = dotModel(x, y) && valid && (!ben || visBefore);
    if (!rstN || !ben) tickCount = 0;
    else if (tick)     tickCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      driveCycle(708, 100, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (pixel_on !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset cycle=%0d got=%0b want=0", i, pixel_on);
      end
    end
  endtask

  task automatic test_points();
    int px[14] = '{700, 710, 708, 708, 720, 720, 713, 714, 706, 705, 699, 713, 706, 719};
    int py[14] = '{72,  90,  100, 84,  100, 112, 103, 103, 80,  80,  84,  87,  79,  111};
    bit pe[14] = '{0,   0,   1,   1,   0,   0,   1,   0,   1,   0,   0,   1,   0,   0};
    for (int i = 0; i < 14; i++) begin
      driveCycle(px[i], py[i], 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (pixel_on !== pe[i]) begin
        bad++;
        $display("[TB] FAIL point (%0d,%0d) got=%0b want=%0b", px[i], py[i], pixel_on, pe[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    driveCycle(708, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (pixel_on !== 1'b0) begin
      bad++;
      $display("[TB] FAIL valid_gating got=%0b want=0", pixel_on);
    end
  endtask

  task automatic test_reset_midframe();
    driveCycle(708, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (pixel_on !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset got=%0b want=1", pixel_on);
    end
    driveCycle(708, 100, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (pixel_on !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midframe_reset got=%0b want=0", pixel_on);
    end
    driveCycle(708, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (pixel_on !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release got=%0b want=1", pixel_on);
    end
  endtask

  // Hand-derived sequence for a half-period of two ticks, holding a lit pixel.
  task automatic test_blink();
    bit tk[13]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
    bit be[13]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit exp[13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    for (int i = 0; i < 13; i++) begin
      driveCycle(708, 100, 1'b1, tk[i], be[i], 1'b1);
      total++;
      if (pixel_on !== exp[i]) begin
        bad++;
        $display("[TB] FAIL blink step=%0d got=%0b want=%0b", i, pixel_on, exp[i]);
      end
    end
  endtask

  // Dense sweep around the box; every pixel outside the window is covered by
  // the box bounds, so 128 lit pixels here means 128 in the whole raster.
  task automatic test_window_sweep();
    int lit;
    lit = 0;
    for (int y = 60; y < 120; y++) begin
      for (int x = 680; x < 740; x++) begin
        driveCycle(x, y, 1'b1, 1'b0, 1'b0, 1'b1);
        if (pixel_on === 1'b1) lit++;
        total++;
        if (pixel_on !== expOn) begin
          bad++;
          $display("[TB] FAIL sweep (%0d,%0d) got=%0b want=%0b", x, y, pixel_on, expOn);
        end
      end
    end
    total++;
    if (lit != 128) begin
      bad++;
      $display("[TB] FAIL sweep_count got=%0d want=128", lit);
    end
  endtask

  task automatic test_random();
    bit ben;
    int x;
    int y;
    ben = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) ben = ~ben;
      if ($urandom_range(0, 1) == 0) begin
        x = $urandom_range(690, 725);
        y = $urandom_range(65, 115);
      end else begin
        x = $urandom_range(0, 1279);
        y = $urandom_range(0, 719);
      end
      driveCycle(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 ben, $urandom_range(0, 199) != 0);
      total++;
      if (pixel_on !== expOn) begin
        bad++;
        $display("[TB] FAIL random i=%0d (%0d,%0d) got=%0b want=%0b", i, x, y, pixel_on, expOn);
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    tickCount   = 0;
    expOn       = 1'b0;
    rst_n       = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_valid = 1'b0;
    frame_tick  = 1'b0;
    blink_en    = 1'b0;
    test_reset();
    test_points();
    test_valid_gating();
    test_reset_midframe();
    test_blink();
    test_window_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
